// File: rtl/raycast_pkg.sv
// Shared raycaster constants: screen geometry, frame buffer sizing and the
// buffer-controller state type.
package raycast_pkg;

    localparam int unsigned RC_SCREEN_WIDTH  = 320;
    localparam int unsigned RC_SCREEN_HEIGHT = 180;
    localparam int unsigned FB_DEPTH         = RC_SCREEN_WIDTH * RC_SCREEN_HEIGHT;
    localparam int unsigned FB_OFF_W         = 16;
    localparam int unsigned FB_ADDR_W        = FB_OFF_W + 1;

    typedef enum logic {
        WRITING = 1'b0,
        READY   = 1'b1
    } fb_state_e;

endpackage

// File: rtl/fb_bram.sv
// Two-buffer dual-port pixel RAM: port A write-only, port B read-only with a
// 2-cycle registered read. Address is {buffer index, offset}.
module fb_bram
    import raycast_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = FB_DEPTH
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 a_we_in,
    input  logic [FB_ADDR_W-1:0] a_addr_in,
    input  logic [DATA_W-1:0]    a_din_in,
    input  logic [FB_ADDR_W-1:0] b_addr_in,
    input  logic                 b_keep_in,
    output logic [DATA_W-1:0]    b_dout_out
);

    logic [DATA_W-1:0] mem [2][DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] dout_d;
    logic [DATA_W-1:0] dout_q;

    always_ff @(posedge clk_in) begin
        if (a_we_in) begin
            mem[a_addr_in[FB_OFF_W]][a_addr_in[FB_OFF_W-1:0]] <= a_din_in;
        end
    end

    always_ff @(posedge clk_in) begin
        rd_data_q <= mem[b_addr_in[FB_OFF_W]][b_addr_in[FB_OFF_W-1:0]];
    end

    // Output register doubles as the blanking gate for out-of-range reads.
    always_comb begin
        dout_d = b_keep_in ? rd_data_q : '0;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign b_dout_out = dout_q;

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Double-buffered frame store: the raycaster fills the back buffer while the
// video side scans the front buffer upscaled to 1280x720; buffers swap on frame start.
module frame_buffer_ctrl
    import raycast_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH   = 16,
    parameter int unsigned SCREEN_WIDTH  = RC_SCREEN_WIDTH,
    parameter int unsigned SCREEN_HEIGHT = RC_SCREEN_HEIGHT,
    parameter int unsigned SCALE_SHIFT   = 2
) (
    input  logic                   pixel_clk_in,
    input  logic                   rst_in,
    input  logic                   ray_valid_in,
    input  logic [FB_OFF_W-1:0]    ray_address_in,
    input  logic [PIXEL_WIDTH-1:0] ray_pixel_in,
    input  logic                   ray_last_pixel_in,
    output logic                   ray_ready_out,
    input  logic [10:0]            hcount_in,
    input  logic [9:0]             vcount_in,
    input  logic                   new_frame_in,
    output logic [PIXEL_WIDTH-1:0] pixel_out,
    output logic                   front_sel_out,
    output logic                   frame_swapped_out,
    output logic                   addr_error_out
);

    localparam int unsigned H_VIS = SCREEN_WIDTH << SCALE_SHIFT;
    localparam int unsigned V_VIS = SCREEN_HEIGHT << SCALE_SHIFT;

    fb_state_e            state_d, state_q;
    logic                 front_sel_d, front_sel_q;
    logic                 ray_ready_d, ray_ready_q;
    logic                 swap_d, swap_q;
    logic                 addr_err_d, addr_err_q;
    logic [FB_ADDR_W-1:0] rd_addr_d, rd_addr_q;
    logic                 rd_vld_d, rd_vld_q;
    logic                 rd_vld2_q;
    logic                 wr_en_c;
    logic [FB_ADDR_W-1:0] wr_addr_c;
    logic                 rd_in_range_c;
    logic [FB_OFF_W-1:0]  rd_off_c;

    // Write-side control: accept while WRITING, swap only from READY.
    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        swap_d      = 1'b0;
        addr_err_d  = addr_err_q;
        wr_en_c     = 1'b0;
        wr_addr_c   = {~front_sel_q, ray_address_in};

        unique case (state_q)
            WRITING: begin
                if (ray_valid_in && ray_ready_q) begin
                    if ({1'b0, ray_address_in} < FB_ADDR_W'(FB_DEPTH)) begin
                        wr_en_c = 1'b1;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                    if (ray_last_pixel_in) begin
                        state_d = READY;
                    end
                end
            end
            READY: begin
                if (new_frame_in) begin
                    state_d     = WRITING;
                    front_sel_d = ~front_sel_q;
                    swap_d      = 1'b1;
                end
            end
            default: state_d = WRITING;
        endcase

        ray_ready_d = (state_d == WRITING);
    end

    // Read address stage; the buffer index is captured here so a swap cannot
    // redirect reads already in flight.
    always_comb begin
        rd_in_range_c = (32'(hcount_in) < H_VIS) && (32'(vcount_in) < V_VIS);
        rd_off_c      = FB_OFF_W'(hcount_in >> SCALE_SHIFT)
                      + FB_OFF_W'(vcount_in >> SCALE_SHIFT) * FB_OFF_W'(SCREEN_WIDTH);
        rd_vld_d      = rd_in_range_c;
        rd_addr_d     = {front_sel_q, (rd_in_range_c ? rd_off_c : '0)};
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= WRITING;
            front_sel_q <= 1'b0;
            ray_ready_q <= 1'b1;
            swap_q      <= 1'b0;
            addr_err_q  <= 1'b0;
            rd_addr_q   <= '0;
            rd_vld_q    <= 1'b0;
            rd_vld2_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            ray_ready_q <= ray_ready_d;
            swap_q      <= swap_d;
            addr_err_q  <= addr_err_d;
            rd_addr_q   <= rd_addr_d;
            rd_vld_q    <= rd_vld_d;
            rd_vld2_q   <= rd_vld_q;
        end
    end

    fb_bram #(
        .DATA_W (PIXEL_WIDTH),
        .DEPTH  (FB_DEPTH)
    ) u_fb_bram (
        .clk_in     (pixel_clk_in),
        .rst_in     (rst_in),
        .a_we_in    (wr_en_c),
        .a_addr_in  (wr_addr_c),
        .a_din_in   (ray_pixel_in),
        .b_addr_in  (rd_addr_q),
        .b_keep_in  (rd_vld2_q),
        .b_dout_out (pixel_out)
    );

    assign ray_ready_out     = ray_ready_q;
    assign front_sel_out     = front_sel_q;
    assign frame_swapped_out = swap_q;
    assign addr_error_out    = addr_err_q;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Directed bench for frame_buffer_ctrl with a cycle-level reference model
// compared on every falling edge plus literal spot checks.
module tb_frame_buffer_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ray_valid;
    logic [15:0] ray_addr;
    logic [15:0] ray_pix;
    logic        ray_last;
    logic        ray_ready;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        new_frame;
    logic [15:0] pixel;
    logic        front_sel;
    logic        swapped;
    logic        addr_err;

    int n_checks = 0;
    int n_errors = 0;

    frame_buffer_ctrl dut (
        .pixel_clk_in      (clk),
        .rst_in            (rst),
        .ray_valid_in      (ray_valid),
        .ray_address_in    (ray_addr),
        .ray_pixel_in      (ray_pix),
        .ray_last_pixel_in (ray_last),
        .ray_ready_out     (ray_ready),
        .hcount_in         (hcount),
        .vcount_in         (vcount),
        .new_frame_in      (new_frame),
        .pixel_out         (pixel),
        .front_sel_out     (front_sel),
        .frame_swapped_out (swapped),
        .addr_error_out    (addr_err)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] m_mem   [2][57600];
    bit          m_known [2][57600];
    bit          m_writing, m_front, m_err, m_swap;
    bit          a_inr, b_inr, b_known, c_known;
    bit          a_sel;
    logic [15:0] a_off, b_val, c_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pixel at video (h,v) appears 3 cycles later from the buffer that
    // was front when (h,v) was sampled; writes land in the other buffer.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_writing = 1'b1; m_front = 1'b0; m_err = 1'b0; m_swap = 1'b0;
            a_inr = 1'b0; a_sel = 1'b0; a_off = '0;
            b_inr = 1'b0; b_known = 1'b1; b_val = '0;
            c_known = 1'b1; c_val = '0;
        end else begin
            c_known = !b_inr || b_known;
            c_val   = b_inr ? b_val : 16'h0;
            b_inr   = a_inr;
            b_known = a_inr ? m_known[a_sel][a_off] : 1'b1;
            b_val   = a_inr ? m_mem[a_sel][a_off] : 16'h0;
            a_inr   = (int'(hcount) < 1280) && (int'(vcount) < 720);
            a_sel   = m_front;
            a_off   = a_inr ? 16'((int'(hcount) / 4) + (int'(vcount) / 4) * 320) : 16'h0;
            m_swap  = 1'b0;
            if (m_writing) begin
                if (ray_valid) begin
                    if (int'(ray_addr) < 57600) begin
                        m_mem[!m_front][ray_addr]   = ray_pix;
                        m_known[!m_front][ray_addr] = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                    if (ray_last) m_writing = 1'b0;
                end
            end else if (new_frame) begin
                m_front   = !m_front;
                m_writing = 1'b1;
                m_swap    = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("cmp_ray_ready", 32'(ray_ready), 32'(m_writing));
            chk("cmp_front_sel", 32'(front_sel), 32'(m_front));
            chk("cmp_swapped", 32'(swapped), 32'(m_swap));
            chk("cmp_addr_err", 32'(addr_err), 32'(m_err));
            if (c_known) chk("cmp_pixel", 32'(pixel), 32'(c_val));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] pix, input logic last);
        ray_valid = 1'b1; ray_addr = addr; ray_pix = pix; ray_last = last;
        tick();
        ray_valid = 1'b0; ray_last = 1'b0;
    endtask

    task automatic pulse_nf();
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
    endtask

    task automatic rd(input int h, input int v, input logic [15:0] exp, input string name);
        hcount = 11'(h); vcount = 10'(v);
        repeat (3) tick();
        chk(name, 32'(pixel), 32'(exp));
    endtask

    initial begin
        rst = 1'b1; ray_valid = 1'b0; ray_addr = '0; ray_pix = '0; ray_last = 1'b0;
        hcount = 11'd1300; vcount = '0; new_frame = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready", 32'(ray_ready), 32'd1);
        chk("rst_front", 32'(front_sel), 32'd0);
        chk("rst_swapped", 32'(swapped), 32'd0);
        chk("rst_err", 32'(addr_err), 32'd0);
        chk("rst_pixel", 32'(pixel), 32'd0);

        // Basic fill, swap, upscaled readback
        wr(16'd0, 16'h1234, 1'b1);
        chk("t1_ready_low", 32'(ray_ready), 32'd0);
        pulse_nf();
        chk("t1_swap_pulse", 32'(swapped), 32'd1);
        chk("t1_front", 32'(front_sel), 32'd1);
        tick();
        chk("t1_swap_once", 32'(swapped), 32'd0);
        for (int v = 0; v < 4; v++)
            for (int h = 0; h < 4; h++)
                rd(h, v, 16'h1234, "t1_pixel");

        // Last address and visible-area boundary
        wr(16'd57599, 16'hBEEF, 1'b1);
        pulse_nf();
        chk("t2_front", 32'(front_sel), 32'd0);
        rd(1279, 719, 16'hBEEF, "t2_corner");
        rd(1280, 0, 16'h0000, "t2_h_oob");
        rd(0, 720, 16'h0000, "t2_v_oob");

        // Out-of-range write
        wr(16'd60000, 16'hAAAA, 1'b0);
        chk("t3_err_set", 32'(addr_err), 32'd1);
        wr(16'd5, 16'h5555, 1'b1);
        chk("t3_err_hold", 32'(addr_err), 32'd1);

        // Writes ignored while READY
        ray_valid = 1'b1; ray_addr = 16'd0; ray_pix = 16'hDEAD;
        repeat (100) tick();
        chk("t4_ready_low", 32'(ray_ready), 32'd0);
        ray_valid = 1'b0;
        pulse_nf();
        chk("t4_ready_after_swap", 32'(ray_ready), 32'd1);
        chk("t4_swap", 32'(swapped), 32'd1);
        chk("t4_front", 32'(front_sel), 32'd1);
        rd(0, 0, 16'h1234, "t4_no_write");
        rd(20, 0, 16'h5555, "t4_pix5");

        // Last pixel and new_frame in the same cycle
        ray_valid = 1'b1; ray_addr = 16'd7; ray_pix = 16'h7777; ray_last = 1'b1; new_frame = 1'b1;
        tick();
        ray_valid = 1'b0; ray_last = 1'b0; new_frame = 1'b0;
        chk("t5_no_swap", 32'(swapped), 32'd0);
        chk("t5_front_kept", 32'(front_sel), 32'd1);
        chk("t5_ready_low", 32'(ray_ready), 32'd0);
        repeat (5) tick();
        chk("t5_still_front", 32'(front_sel), 32'd1);
        pulse_nf();
        chk("t5_swap", 32'(swapped), 32'd1);
        chk("t5_front", 32'(front_sel), 32'd0);
        rd(28, 0, 16'h7777, "t5_pix7");
        chk("t5_err_sticky", 32'(addr_err), 32'd1);

        // Asynchronous reset mid-sweep
        wr(16'd9, 16'h9999, 1'b1);
        pulse_nf();
        chk("t6_front", 32'(front_sel), 32'd1);
        hcount = '0; vcount = '0;
        wr(16'd1, 16'h0101, 1'b0);
        wr(16'd2, 16'h0202, 1'b0);
        tick();
        chk("t6_pixel_pre", 32'(pixel), 32'h1234);
        #3 rst = 1'b1;
        #1;
        chk("t6_rst_ready", 32'(ray_ready), 32'd1);
        chk("t6_rst_front", 32'(front_sel), 32'd0);
        chk("t6_rst_swapped", 32'(swapped), 32'd0);
        chk("t6_rst_err", 32'(addr_err), 32'd0);
        chk("t6_rst_pixel", 32'(pixel), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_restart_ready", 32'(ray_ready), 32'd1);
        wr(16'd3, 16'h3333, 1'b1);
        chk("t6_last_ready", 32'(ray_ready), 32'd0);
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
